// File: rtl/b_lut_read_arbiter_pkg.sv
// Shared defaults and FSM encoding for the B_LUT read arbiter.
package b_lut_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_LEN_WIDTH  = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

endpackage

// File: rtl/b_lut_read_arbiter_if.sv
// Request/response bundle between the effect engines and the B_LUT read arbiter.
interface b_lut_read_arbiter_if
   import b_lut_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic                          rsp_last;

   modport master (
      output req_valid, req_addr, req_len,
      input  req_ready, rsp_valid, rsp_data, rsp_last
   );

   modport slave (
      input  req_valid, req_addr, req_len,
      output req_ready, rsp_valid, rsp_data, rsp_last
   );

endinterface

// File: rtl/b_lut_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending request at or after the pointer.
module b_lut_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   int j;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      j         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!grant_any && req[j[IDX_W-1:0]]) begin
            grant_any             = 1'b1;
            grant_idx             = j[IDX_W-1:0];
            grant[j[IDX_W-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/b_lut_read_arbiter.sv
// Round-robin burst sequencer sharing the single-port B_LUT ROM between effect engines.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | no burst issuing; accepts the round-robin winner this cycle
//  ST_BURST | one ROM read per cycle for the latched owner until cnt hits 0
module b_lut_read_arbiter
   import b_lut_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   b_lut_read_arbiter_if.slave   bus,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rd_data,
   output logic                  busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, owner_q, grant_idx;
   logic [NUM_REQ-1:0]    grant;
   logic                  grant_any;
   logic [LEN_WIDTH-1:0]  cnt_q, sel_len;
   logic [ADDR_WIDTH-1:0] addr_q, sel_addr;
   logic                  accept, issue, issue_last;

   logic [RD_LATENCY-1:0] pipe_v, pipe_last;
   logic [IDX_W-1:0]      pipe_id [RD_LATENCY];

   b_lut_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req       (bus.req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign accept     = (state_q == ST_IDLE) & grant_any;
   assign issue      = (state_q == ST_BURST);
   assign issue_last = issue & (cnt_q == '0);

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (grant_any)  state_d = ST_BURST;
         ST_BURST: if (issue_last) state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         cnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
      end else if (accept) begin
         addr_q  <= sel_addr;
         cnt_q   <= sel_len;
         owner_q <= grant_idx;
         ptr_q   <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (issue) begin
         addr_q  <= addr_q + 1'b1;
         cnt_q   <= cnt_q - 1'b1;
      end
   end

   // Tag travels alongside the ROM read so the word can be routed when it returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v    <= '0;
         pipe_last <= '0;
         for (int i = 0; i < RD_LATENCY; i++) pipe_id[i] <= '0;
      end else begin
         pipe_v[0]    <= issue;
         pipe_last[0] <= issue_last;
         pipe_id[0]   <= owner_q;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_last[i] <= pipe_last[i-1];
            pipe_id[i]   <= pipe_id[i-1];
         end
      end
   end

   assign rom_addr      = addr_q;
   assign bus.req_ready = grant & {NUM_REQ{accept & rst_n}};
   assign bus.rsp_valid = pipe_v[RD_LATENCY-1] ? (NUM_REQ'(1) << pipe_id[RD_LATENCY-1]) : '0;
   assign bus.rsp_last  = pipe_v[RD_LATENCY-1] & pipe_last[RD_LATENCY-1];
   assign bus.rsp_data  = rom_rd_data;
   assign busy          = issue | (|pipe_v);

endmodule

// File: tb/tb_b_lut_read_arbiter.sv
// Bench for b_lut_read_arbiter: latency-1 and latency-2 instances share stimulus and a burst-schedule model.
module tb_b_lut_read_arbiter;
   import b_lut_pkg::*;

   localparam int N    = 4;
   localparam int AW   = 10;
   localparam int DW   = 8;
   localparam int LW   = 4;
   localparam int MAXC = 2000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid = '0;
   logic [N*AW-1:0] req_addr  = '0;
   logic [N*LW-1:0] req_len   = '0;

   b_lut_read_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus1 ();
   b_lut_read_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus2 ();

   assign bus1.req_valid = req_valid;
   assign bus1.req_addr  = req_addr;
   assign bus1.req_len   = req_len;
   assign bus2.req_valid = req_valid;
   assign bus2.req_addr  = req_addr;
   assign bus2.req_len   = req_len;

   logic [AW-1:0] rom_addr1, rom_addr2;
   logic [DW-1:0] rd1, rd2a, rd2;
   logic          busy1, busy2;

   b_lut_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .rom_addr(rom_addr1), .rom_rd_data(rd1), .busy(busy1));
   b_lut_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2), .rom_addr(rom_addr2), .rom_rd_data(rd2), .busy(busy2));

   // ROM model: data = addr[7:0] ^ 0xA5 with one or two cycles of latency
   always @(posedge clk) begin
      rd1  <= rom_addr1[7:0] ^ 8'hA5;
      rd2a <= rom_addr2[7:0] ^ 8'hA5;
      rd2  <= rd2a;
   end

   int          checks = 0;
   int          errors = 0;
   int          cyc, free_at, ptr, last_rst;
   bit          issue_at [MAXC];
   logic [AW-1:0] exp_rom [MAXC];
   int          exp_id   [2][MAXC];
   logic [7:0]  exp_dat  [2][MAXC];
   bit          exp_last [2][MAXC];
   int          gq [$];
   int          exp_order [5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
      req_addr[i*AW +: AW] = a;
      req_len[i*LW +: LW]  = l;
      req_valid[i]         = 1'b1;
   endtask

   // One cycle: check this cycle's outputs against the schedule, record an acceptance, advance.
   task automatic tick();
      int g;
      logic [N-1:0] er;
      logic [AW-1:0] a;
      int len, t, eid, lat;
      logic [N-1:0] obs_v;
      logic [7:0] obs_d;
      logic obs_l, obs_b, be;
      #1;
      g  = -1;
      er = '0;
      if (rst_n && cyc >= free_at)
         for (int i = 0; i < N; i++)
            if (g < 0 && req_valid[(ptr + i) % N]) g = (ptr + i) % N;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready_l1", 32'(bus1.req_ready), 32'(er));
      chk("req_ready_l2", 32'(bus2.req_ready), 32'(er));
      for (int i = 0; i < N; i++) if (bus1.req_ready[i]) gq.push_back(i);

      if (!rst_n) begin
         chk("rst_rsp_valid_l1", 32'(bus1.rsp_valid), 0);
         chk("rst_rsp_valid_l2", 32'(bus2.rsp_valid), 0);
         chk("rst_rsp_last", 32'({bus1.rsp_last, bus2.rsp_last}), 0);
         chk("rst_busy", 32'({busy1, busy2}), 0);
         chk("rst_rom_addr_l1", 32'(rom_addr1), 0);
         chk("rst_rom_addr_l2", 32'(rom_addr2), 0);
         last_rst = cyc;
         free_at  = 0;
         ptr      = 0;
         for (int k = cyc; k < MAXC; k++) begin
            issue_at[k] = 1'b0;
            exp_id[0][k] = -1;
            exp_id[1][k] = -1;
         end
      end else begin
         if (issue_at[cyc]) begin
            chk("rom_addr_l1", 32'(rom_addr1), 32'(exp_rom[cyc]));
            chk("rom_addr_l2", 32'(rom_addr2), 32'(exp_rom[cyc]));
         end
         for (int L = 0; L < 2; L++) begin
            lat   = L + 1;
            obs_v = (L == 0) ? bus1.rsp_valid : bus2.rsp_valid;
            obs_d = (L == 0) ? bus1.rsp_data  : bus2.rsp_data;
            obs_l = (L == 0) ? bus1.rsp_last  : bus2.rsp_last;
            obs_b = (L == 0) ? busy1 : busy2;
            eid   = exp_id[L][cyc];
            chk(L == 0 ? "rsp_valid_l1" : "rsp_valid_l2", 32'(obs_v), (eid >= 0) ? (32'd1 << eid) : 32'd0);
            if (eid >= 0) begin
               chk(L == 0 ? "rsp_data_l1" : "rsp_data_l2", 32'(obs_d), 32'(exp_dat[L][cyc]));
               chk(L == 0 ? "rsp_last_l1" : "rsp_last_l2", 32'(obs_l), 32'(exp_last[L][cyc]));
            end else begin
               chk(L == 0 ? "rsp_last_idle_l1" : "rsp_last_idle_l2", 32'(obs_l), 0);
            end
            be = 1'b0;
            for (int j = 0; j <= lat; j++) begin
               t = cyc - j;
               if (t >= 0 && t > last_rst && issue_at[t]) be = 1'b1;
            end
            chk(L == 0 ? "busy_l1" : "busy_l2", 32'(obs_b), 32'(be));
         end
      end

      if (g >= 0) begin
         a   = req_addr[g*AW +: AW];
         len = int'(req_len[g*LW +: LW]);
         for (int k = 0; k <= len; k++) begin
            t = cyc + 1 + k;
            issue_at[t] = 1'b1;
            exp_rom[t]  = AW'(int'(a) + k);
            for (int L = 0; L < 2; L++) begin
               exp_id[L][t+L+1]   = g;
               exp_dat[L][t+L+1]  = exp_rom[t][7:0] ^ 8'hA5;
               exp_last[L][t+L+1] = (k == len);
            end
         end
         free_at = cyc + len + 2;
         ptr     = (g + 1) % N;
      end

      @(negedge clk);
      cyc++;
      if (g >= 0) req_valid[g] = 1'b0;
   endtask

   task automatic wait_clear(input int budget);
      int n;
      n = 0;
      while (req_valid != '0 && n < budget) begin
         tick();
         n++;
      end
      chk("wait_clear_timeout", 32'(req_valid), 0);
   endtask

   initial begin
      for (int k = 0; k < MAXC; k++) begin
         exp_id[0][k] = -1;
         exp_id[1][k] = -1;
         issue_at[k]  = 1'b0;
      end
      cyc = 0; free_at = 0; ptr = 0; last_rst = -1;

      #2 rst_n = 1'b0;
      @(negedge clk);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // single word
      set_req(0, 10'h010, 4'd0);
      tick();
      repeat (4) tick();

      // address wrap across 0x3FF
      set_req(1, 10'h3FE, 4'd3);
      tick();
      repeat (8) tick();

      // contention straight after reset
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      gq.delete();
      for (int i = 0; i < N; i++) set_req(i, AW'(10'h100 + i*16), 4'd1);
      tick();
      set_req(0, 10'h180, 4'd1);
      wait_clear(40);
      repeat (5) tick();
      chk("grant_order_len", 32'(gq.size()), 5);
      for (int i = 0; i < 5; i++)
         if (i < gq.size()) chk("grant_order", 32'(gq[i]), 32'(exp_order[i]));

      // reset during the 5th issue of a 16-word burst
      set_req(2, 10'h200, 4'd15);
      tick();
      repeat (4) tick();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      gq.delete();
      set_req(0, 10'h020, 4'd2);
      set_req(2, 10'h220, 4'd2);
      wait_clear(20);
      repeat (6) tick();
      chk("post_reset_grants", 32'(gq.size()), 2);
      if (gq.size() > 0) chk("post_reset_first", 32'(gq[0]), 0);

      // withdrawn request during a burst
      set_req(0, 10'h050, 4'd5);
      tick(); tick();
      set_req(3, 10'h060, 4'd2);
      tick();
      req_valid[3] = 1'b0;
      repeat (10) tick();

      // randomized traffic with occasional withdrawals
      repeat (400) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0)
               set_req(i, AW'($urandom_range(0, 1023)), LW'($urandom_range(0, 15)));
            else if (req_valid[i] && $urandom_range(0, 15) == 0)
               req_valid[i] = 1'b0;
         end
         tick();
      end
      req_valid = '0;
      repeat (25) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
